// File: rtl/hilo_ctrl.sv
// HI/LO register controller for a MIPS-style multiply unit: issues operands to an
// external signed multiplier, waits MUL_LAT edges, and captures the 64-bit product.
module hilo_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] z,
  output logic        stall,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd3;
  localparam logic [2:0] OP_MTLO  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic          uns;
  logic [31:0]   op_a, op_b;
  logic          is_op, accept, is_mul, done;
  logic [63:0]   z_fix;

  assign busy   = (state == BUSY);
  assign is_op  = (op >= OP_MULT) && (op <= OP_MFLO);
  assign stall  = op_valid & busy & is_op;
  assign accept = op_valid & is_op & ~stall;
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign done   = busy && (cnt == '0);

  // Unsigned product from a signed multiplier: add back b<<32 / a<<32 for each
  // operand whose top bit was read as negative.
  assign z_fix = z + (op_a[31] ? {op_b, 32'b0} : 64'b0)
                   + (op_b[31] ? {op_a, 32'b0} : 64'b0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nx = BUSY;
      BUSY:    if (cnt == '0)        state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi       <= '0;
      lo       <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      uns      <= 1'b0;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (busy && cnt != '0) cnt <= cnt - 1'b1;
      if (done) begin
        {hi, lo} <= uns ? z_fix : z;
      end
      if (accept) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            mul_a <= rs_val;
            mul_b <= rt_val;
            op_a  <= rs_val;
            op_b  <= rt_val;
            uns   <= (op == OP_MULTU);
            cnt   <= CW'(MUL_LAT);
          end
          OP_MTHI: hi <= rs_val;
          OP_MTLO: lo <= rs_val;
          OP_MFHI: begin rd_data <= hi; rd_valid <= 1'b1; end
          OP_MFLO: begin rd_data <= lo; rd_valid <= 1'b1; end
          default: ;
        endcase
      end
    end
  end
endmodule
